pb_prog_loader: RTL

- Sits between the PicoBlaze core and its 1024x18 instruction RAM, and owns that RAM's single port.
- In RUN it passes CPU fetches straight through to the RAM.
- A framed byte stream (UART/JTAG bridge) reloads the program: the loader holds the CPU in reset, writes the words sequentially from address 0, verifies a checksum, then releases the CPU.

---
 rtl/pb_prog_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pb_prog_loader.sv
// PicoBlaze program loader: passes CPU fetches to the instruction RAM in RUN and reloads it from a framed byte stream.
// Fetch path is combinational address / 1-cycle RAM data; rx_ready drops during WRITE, RELEASE and ERR to stall the byte source.
module pb_prog_loader #(
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         RELEASE_CYCLES = 4,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    input  logic [9:0]  i_cpu_address,
    output logic [17:0] o_cpu_instruction,
    output logic        o_cpu_reset,
    output logic [9:0]  o_ram_address,
    output logic [17:0] o_ram_di,
    output logic        o_ram_we,
    input  logic [17:0] i_ram_do,
    output logic        o_load_busy,
    output logic        o_load_error
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = $clog2(RELEASE_CYCLES + 1);

    typedef enum logic [3:0] {
        S_RUN, S_CNT_H, S_CNT_L, S_D0, S_D1, S_D2, S_WRITE, S_CHK, S_RELEASE, S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [10:0] r_cnt;
    logic [17:0] r_word;
    logic [9:0]  r_wptr;
    logic [7:0]  r_sum;
    logic [TW-1:0] r_idle;
    logic [RW-1:0] r_rel_cnt;
    logic        r_cpu_hold;
    logic        r_busy;
    logic        r_error;

    logic        w_accept;
    logic        w_waiting;
    logic        w_timeout;
    logic        w_rel_done;
    logic [10:0] w_cnt_full;
    logic        w_cnt_bad;

    assign w_accept   = i_rx_valid & o_rx_ready;
    assign w_waiting  = r_state inside {S_CNT_H, S_CNT_L, S_D0, S_D1, S_D2, S_CHK};
    assign w_timeout  = w_waiting && !w_accept && (r_idle == TW'(TIMEOUT_CYCLES - 1));
    assign w_rel_done = (r_rel_cnt <= RW'(1));
    assign w_cnt_full = {r_cnt[10:8], i_rx_data};
    assign w_cnt_bad  = (w_cnt_full == 11'd0) || (w_cnt_full > 11'd1024);

    assign o_cpu_reset  = r_cpu_hold;
    assign o_load_busy  = r_busy;
    assign o_load_error = r_error;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_RELEASE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN:     if (w_accept && i_rx_data == SYNC_BYTE) w_next = S_CNT_H;
            S_CNT_H:   if (w_accept) w_next = S_CNT_L;
            S_CNT_L:   if (w_accept) w_next = w_cnt_bad ? S_ERR : S_D0;
            S_D0:      if (w_accept) w_next = S_D1;
            S_D1:      if (w_accept) w_next = S_D2;
            S_D2:      if (w_accept) w_next = S_WRITE;
            S_WRITE:   w_next = (r_cnt == 11'd1) ? S_CHK : S_D0;
            S_CHK:     if (w_accept) w_next = (i_rx_data == r_sum) ? S_RELEASE : S_ERR;
            S_RELEASE: if (w_rel_done) w_next = S_RUN;
            S_ERR:     w_next = S_RUN;
            default:   w_next = S_RUN;
        endcase
        if (w_timeout) w_next = S_ERR;
    end

    always_comb begin
        o_rx_ready        = 1'b0;
        o_ram_we          = 1'b0;
        o_ram_di          = '0;
        o_ram_address     = r_wptr;
        o_cpu_instruction = '0;
        case (r_state)
            S_RUN: begin
                o_rx_ready        = 1'b1;
                o_ram_address     = i_cpu_address;
                o_cpu_instruction = i_ram_do;
            end
            S_CNT_H, S_CNT_L, S_D0, S_D1, S_D2, S_CHK: o_rx_ready = 1'b1;
            S_WRITE: begin
                o_ram_we = 1'b1;
                o_ram_di = r_word;
            end
            S_RELEASE: o_cpu_instruction = i_ram_do;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_word     <= '0;
            r_wptr     <= '0;
            r_sum      <= '0;
            r_idle     <= '0;
            r_rel_cnt  <= RW'(RELEASE_CYCLES);
            r_cpu_hold <= 1'b1;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_waiting && !w_accept) r_idle <= r_idle + TW'(1);
            else                        r_idle <= '0;

            // Checksum covers count and data bytes, never the SYNC or checksum byte itself.
            if (w_accept && (r_state inside {S_CNT_H, S_CNT_L, S_D0, S_D1, S_D2}))
                r_sum <= r_sum + i_rx_data;

            case (r_state)
                S_RUN: if (w_accept && i_rx_data == SYNC_BYTE) begin
                    r_cpu_hold <= 1'b1;
                    r_busy     <= 1'b1;
                    r_error    <= 1'b0;
                    r_sum      <= '0;
                    r_wptr     <= '0;
                end
                S_CNT_H: if (w_accept) r_cnt[10:8]   <= i_rx_data[2:0];
                S_CNT_L: if (w_accept) r_cnt[7:0]    <= i_rx_data;
                S_D0:    if (w_accept) r_word[17:16] <= i_rx_data[1:0];
                S_D1:    if (w_accept) r_word[15:8]  <= i_rx_data;
                S_D2:    if (w_accept) r_word[7:0]   <= i_rx_data;
                S_WRITE: begin
                    r_wptr <= r_wptr + 10'd1;
                    r_cnt  <= r_cnt - 11'd1;
                end
                S_CHK: if (w_accept && i_rx_data == r_sum) r_rel_cnt <= RW'(RELEASE_CYCLES);
                S_RELEASE: begin
                    if (w_rel_done) begin
                        r_cpu_hold <= 1'b0;
                        r_busy     <= 1'b0;
                    end else begin
                        r_rel_cnt <= r_rel_cnt - RW'(1);
                    end
                end
                default: ;
            endcase

            // A failed frame keeps the CPU held; only a later good frame releases it.
            if (w_next == S_ERR) begin
                r_error <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

endmodule
